// File: rtl/enc_pkg.sv
// Shared encoder definitions: instruction kinds, opcodes, immediate field widths.
// Also holds the signed-fit helper used by the range check.
package enc_pkg;

    typedef enum logic [1:0] {
        KIND_STUR = 2'd0,
        KIND_LDUR = 2'd1,
        KIND_CBZ  = 2'd2,
        KIND_BAD  = 2'd3
    } kind_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic [10:0] OP_STUR  = 11'b111_1100_0000;
    localparam logic [10:0] OP_LDUR  = 11'b111_1100_0010;
    localparam logic [7:0]  OP_CBZ   = 8'b1011_0100;
    localparam int          IMM_D_W  = 9;
    localparam int          IMM_CB_W = 19;

    // True when imm is a sign extension of its low w bits (bits 63..w-1 all equal).
    function automatic logic fits_signed(input logic [63:0] imm, input int w);
        logic [63:0] upper;
        upper = 64'($signed(imm) >>> (w - 1));
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational packing of a 64-bit immediate into a LEGv8 D-type or CB-type word,
// with range checking; an error forces the word to zero.
module imm_pack
    import enc_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [4:0]  rt,
    input  logic [4:0]  rn,
    input  logic [63:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    always_comb begin
        instr = '0;
        err   = 1'b0;
        case (kind_e'(kind))
            KIND_STUR: begin
                err   = !fits_signed(imm, IMM_D_W);
                instr = {OP_STUR, imm[IMM_D_W-1:0], 2'b00, rn, rt};
            end
            KIND_LDUR: begin
                err   = !fits_signed(imm, IMM_D_W);
                instr = {OP_LDUR, imm[IMM_D_W-1:0], 2'b00, rn, rt};
            end
            KIND_CBZ: begin
                err   = !fits_signed(imm, IMM_CB_W);
                instr = {OP_CBZ, imm[IMM_CB_W-1:0], rt};
            end
            default: err = 1'b1;
        endcase
        if (err) begin
            instr = '0;
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Valid/ready wrapped immediate encoder: one-entry output register behind a two-state FSM.
// Define IMM_ENCODER_STATS_EN to build the stat_ok/stat_err counters; otherwise they read 0.
module imm_encoder
    import enc_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rn,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic              out_err,
    output logic [STAT_W-1:0] stat_ok,
    output logic [STAT_W-1:0] stat_err
);

    state_e      state;
    state_e      state_nxt;
    logic        xfer;
    logic [31:0] pack_instr;
    logic        pack_err;

    imm_pack u_pack (
        .kind  (in_kind),
        .rt    (in_rt),
        .rn    (in_rn),
        .imm   (in_imm),
        .instr (pack_instr),
        .err   (pack_err)
    );

    // Reset drives state to EMPTY asynchronously, which also raises in_ready during reset.
    assign in_ready  = (state == EMPTY) || out_ready;
    assign xfer      = in_valid && in_ready;
    assign out_valid = (state == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (xfer) state_nxt = FULL;
            FULL:    if (out_ready && !xfer) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // A new word loads only on a transfer, so a stalled word holds until it is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (xfer) begin
            out_instr <= pack_instr;
            out_err   <= pack_err;
        end
    end

`ifdef IMM_ENCODER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ok  <= '0;
            stat_err <= '0;
        end else if (xfer) begin
            if (pack_err) begin
                stat_err <= stat_err + STAT_W'(1);
            end else begin
                stat_ok <= stat_ok + STAT_W'(1);
            end
        end
    end
`else
    assign stat_ok  = '0;
    assign stat_err = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed encodings, stall/throughput, reset and
// randomized traffic scored against a range/arithmetic reference model.
module tb_imm_encoder;

    localparam int STAT_W = 16;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [4:0]        in_rt;
    logic [4:0]        in_rn;
    logic [63:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic              out_err;
    logic [STAT_W-1:0] stat_ok;
    logic [STAT_W-1:0] stat_err;

    int          total = 0;
    int          bad   = 0;
    int          m_ok  = 0;
    int          m_err = 0;
    logic [32:0] exp_q[$];
    logic        prev_hold = 1'b0;
    logic [32:0] prev_word = '0;
    logic        rand_ready = 1'b0;
    int          hold_cnt = 0;

    imm_encoder #(.STAT_W(STAT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rt     (in_rt),
        .in_rn     (in_rn),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .stat_ok   (stat_ok),
        .stat_err  (stat_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: range check on the signed value, then field placement by arithmetic.
    function automatic logic [32:0] model(input logic [1:0] kind, input logic [4:0] rt,
                                          input logic [4:0] rn, input logic [63:0] imm);
        longint s;
        longint lo;
        longint hi;
        longint base;
        longint word;
        s = longint'(imm);
        case (kind)
            2'd0:    begin base = 64'hF800_0000; lo = -256;    hi = 255;    end
            2'd1:    begin base = 64'hF840_0000; lo = -256;    hi = 255;    end
            2'd2:    begin base = 64'hB400_0000; lo = -262144; hi = 262143; end
            default: return {1'b1, 32'h0};
        endcase
        if (s < lo || s > hi) return {1'b1, 32'h0};
        if (kind == 2'd2)
            word = base + (s & 64'h7FFFF) * 32 + longint'(rt);
        else
            word = base + (s & 64'h1FF) * 4096 + longint'(rn) * 32 + longint'(rt);
        return {1'b0, 32'(word)};
    endfunction

    // Scoreboard: pops on each output transfer, pushes on each input transfer.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                prev_hold = 1'b0;
                m_ok = 0;
                m_err = 0;
            end else begin
                checkOutput("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (prev_hold && out_valid)
                    checkOutput("hold_stable", 64'({out_err, out_instr}), 64'(prev_word));
                if (out_valid && !out_ready)
                    checkOutput("in_ready_full", 64'(in_ready), 64'd0);
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("word", 64'({out_err, out_instr}), 64'(e));
                end
                if (in_valid && in_ready) begin
                    e = model(in_kind, in_rt, in_rn, in_imm);
                    exp_q.push_back(e);
                    if (e[32]) m_err++;
                    else m_ok++;
                end
                prev_hold = out_valid && !out_ready;
                prev_word = {out_err, out_instr};
            end
        end
    end

    task automatic advance();
        @(posedge clk);
        #1;
        if (hold_cnt > 0) begin
            hold_cnt--;
            out_ready = (hold_cnt == 0);
        end else if (rand_ready) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) advance();
    endtask

    // Holds the request until it is accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic [1:0] kind, input logic [4:0] rt,
                                 input logic [4:0] rn, input logic [63:0] imm);
        logic acc;
        in_kind  = kind;
        in_rt    = rt;
        in_rn    = rn;
        in_imm   = imm;
        in_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            acc = in_ready;
            advance();
            if (acc) return;
        end
        checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic directed(input string tag, input logic [1:0] kind, input logic [4:0] rt,
                            input logic [4:0] rn, input logic [63:0] imm,
                            input logic exp_err, input logic [31:0] exp_instr);
        applyStimulus(kind, rt, rn, imm);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_instr"}, 64'(out_instr), 64'(exp_instr));
        checkOutput({tag, "_err"}, 64'(out_err), 64'(exp_err));
        idle(2);
    endtask

    task automatic checkStats(input string tag);
`ifdef IMM_ENCODER_STATS_EN
        checkOutput({tag, "_stat_ok"}, 64'(stat_ok), 64'(STAT_W'(m_ok)));
        checkOutput({tag, "_stat_err"}, 64'(stat_err), 64'(STAT_W'(m_err)));
`else
        checkOutput({tag, "_stat_ok"}, 64'(stat_ok), 64'd0);
        checkOutput({tag, "_stat_err"}, 64'(stat_err), 64'd0);
`endif
    endtask

    function automatic logic [63:0] rand_imm();
        longint bnd[8];
        bnd = '{-257, -256, 255, 256, -262145, -262144, 262143, 262144};
        case ($urandom_range(0, 4))
            0:       return 64'(longint'($urandom_range(0, 510)) - 255);
            1:       return 64'(bnd[$urandom_range(0, 7)]);
            2:       return 64'(longint'($urandom_range(0, 524286)) - 262143);
            3:       return {$urandom, $urandom};
            default: return 64'(longint'($urandom_range(0, 20)) - 10);
        endcase
    endfunction

    function automatic logic [1:0] rand_kind();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 2'd0;
        if (r < 6) return 2'd1;
        if (r < 9) return 2'd2;
        return 2'd3;
    endfunction

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_kind   = 2'd0;
        in_rt     = 5'd0;
        in_rn     = 5'd0;
        in_imm    = 64'd0;
        out_ready = 1'b1;
        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
        checkOutput("rst_out_err", 64'(out_err), 64'd0);
        checkOutput("rst_stat_ok", 64'(stat_ok), 64'd0);
        checkOutput("rst_stat_err", 64'(stat_err), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        directed("ldur_neg4", 2'd1, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hF85FC041);
        directed("stur_8", 2'd0, 5'd3, 5'd4, 64'd8, 1'b0, 32'hF8008083);
        directed("cbz_neg1", 2'd2, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hB4FFFFE5);
        directed("cbz_range", 2'd2, 5'd5, 5'd0, 64'd262144, 1'b1, 32'h0);
        directed("ldur_256", 2'd1, 5'd1, 5'd2, 64'd256, 1'b1, 32'h0);
        directed("kind_bad", 2'd3, 5'd1, 5'd2, 64'd0, 1'b1, 32'h0);
        idle(3);
        checkStats("directed");

        // Four back-to-back requests with the consumer stalled for three cycles.
        out_ready = 1'b0;
        hold_cnt  = 4;
        applyStimulus(2'd0, 5'd10, 5'd11, 64'd12);
        checkOutput("b2b_in_ready", 64'(in_ready), 64'd0);
        checkOutput("b2b_out_valid", 64'(out_valid), 64'd1);
        applyStimulus(2'd1, 5'd13, 5'd14, 64'hFFFF_FFFF_FFFF_FF00);
        applyStimulus(2'd2, 5'd15, 5'd0, 64'd1000);
        applyStimulus(2'd0, 5'd16, 5'd17, 64'd255);
        idle(6);
        checkOutput("b2b_drained", 64'(exp_q.size()), 64'd0);

        // Reset while holding an untaken word.
        out_ready = 1'b0;
        applyStimulus(2'd1, 5'd7, 5'd8, 64'd16);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("mid_rst_out_instr", 64'(out_instr), 64'd0);
        checkOutput("mid_rst_stat_ok", 64'(stat_ok), 64'd0);
        checkOutput("mid_rst_stat_err", 64'(stat_err), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        idle(4);
        checkOutput("rst_no_stale", 64'(out_valid), 64'd0);

        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            applyStimulus(rand_kind(), 5'($urandom), 5'($urandom), rand_imm());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle(10);
        checkOutput("final_drained", 64'(exp_q.size()), 64'd0);
        checkStats("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter STAT_W, default 16, meaning the width of the statistics counters.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the encoder can accept a request.
REQ-006 SHALL have port in_kind, input, 2 bits: instruction kind (0=STUR, 1=LDUR, 2=CBZ, 3=invalid).
REQ-007 SHALL have port in_rt, input, 5 bits: Rt register field.
REQ-008 SHALL have port in_rn, input, 5 bits: Rn register field; ignored for CBZ.
REQ-009 SHALL have port in_imm, input, 64 bits: signed immediate or offset.
REQ-010 SHALL have port out_valid, output, 1 bit: an encoded word is available.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-012 SHALL have port out_instr, output, 32 bits: the encoded LEGv8 instruction.
REQ-013 SHALL have port out_err, output, 1 bit: the immediate was out of range or the kind was invalid.
REQ-014 SHALL have port stat_ok, output, STAT_W bits: count of accepted requests that encoded cleanly.
REQ-015 SHALL have port stat_err, output, STAT_W bits: count of accepted requests flagged with out_err.

Function
REQ-016 SHALL perform the inverse of the datapath sign-extender: pack a 64-bit immediate into its instruction field.
REQ-017 SHALL encode STUR as {11'b111_1100_0000, imm[8:0], 2'b00, rn, rt}.
REQ-018 SHALL encode LDUR as {11'b111_1100_0010, imm[8:0], 2'b00, rn, rt}.
REQ-019 SHALL encode CBZ as {8'b1011_0100, imm[18:0], rt}.
REQ-020 SHALL set err, for D-type kinds (STUR, LDUR), when in_imm[63:8] is not all equal to in_imm[8].
REQ-021 SHALL set err, for CBZ, when in_imm[63:18] is not all equal to in_imm[18].
REQ-022 SHALL set err for kind 3.
REQ-023 SHALL force out_instr to 32'h0 whenever err is set.
REQ-024 SHALL implement a two-state FSM with states EMPTY and FULL.
REQ-025 SHALL drive in_ready = (state==EMPTY) || out_ready, combinationally.
REQ-026 SHALL treat a transfer as in_valid && in_ready, with a latency of 1 cycle: out_valid rises on the edge after acceptance.
REQ-027 SHALL transition EMPTY -> FULL on an input transfer.
REQ-028 SHALL transition FULL -> EMPTY on out_ready with no new transfer.
REQ-029 SHALL stay FULL and load new data when out_ready and an input transfer occur in the same cycle, giving full throughput.
REQ-030 SHALL hold out_instr and out_err stable while out_valid && !out_ready.
REQ-031 SHALL keep out_valid high with no new transfer while FULL and !out_ready.
REQ-032 SHALL derive out_valid = (state==FULL).
REQ-033 SHALL increment stat_ok or stat_err once per input transfer, wrapping modulo 2^STAT_W.

Reset
REQ-034 SHALL, on reset assertion (at any time, including mid-transfer), immediately set the state to EMPTY, out_valid=0, out_instr=0, out_err=0, stat_ok=0 and stat_err=0.
REQ-035 SHALL discard any pending word on reset.
REQ-036 SHALL drive in_ready=1 while reset is asserted.

Configuration
REQ-037 SHALL, with macro IMM_ENCODER_STATS_EN defined, implement the stat_ok and stat_err counters per REQ-033.
REQ-038 SHALL, without IMM_ENCODER_STATS_EN, tie stat_ok and stat_err to 0 and synthesize no counter flops; the ports remain present.

Structure
REQ-039 SHALL take, from the shared package enc_pkg: the kind enum (KIND_STUR, KIND_LDUR, KIND_CBZ, KIND_BAD), the opcode constants OP_STUR, OP_LDUR and OP_CBZ, and the field widths IMM_D_W=9 and IMM_CB_W=19.
REQ-040 SHALL place the combinational packing and range check in sub-module imm_pack; imm_encoder holds only the FSM, the output register and the counters.

Verification
REQ-041 SHALL cover: LDUR, rt=1, rn=2, imm=-4 (64'hFFFF_FFFF_FFFF_FFFC) -> out_instr=32'hF85FC041, out_err=0, after 1 cycle.
REQ-042 SHALL cover: STUR, rt=3, rn=4, imm=8 -> out_instr=32'hF8008083, out_err=0.
REQ-043 SHALL cover: CBZ, rt=5, imm=-1 -> 32'hB4FFFFE5; CBZ with imm=262144 -> out_err=1, out_instr=0, and stat_err increments by 1.
REQ-044 SHALL cover: LDUR with imm=256, and separately kind=3 -> out_err=1, out_instr=0.
REQ-045 SHALL cover: back-to-back stream of 4 requests with out_ready held 0 for 3 cycles -> in_ready=0 while FULL, the first word held stable, then all 4 words delivered in order with no drops and no duplicates.
REQ-046 SHALL cover: reset asserted while FULL and !out_ready -> out_valid=0 immediately, in_ready=1, counters=0, and no stale word after reset is released.
